uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer directly downstream of the UART receiver. Captures each byte strobed out by the receiver into a circular buffer and presents it first-word-fall-through to the CPU-side peripheral bus logic. Tracks fill level, raises a level interrupt at a programmable threshold, and flags overrun when a byte arrives while full.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries; power of two, ≥ 2.
- `IRQ_THRESHOLD`, 1: `irq` asserts when `count` ≥ this value; range 1..`DEPTH`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  byte from receiver; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe: byte available on `rx_data`.
- `pop`  in  1  consume head entry; ignored when `empty`.
- `flush`  in  1  synchronous discard of all entries.
- `overrun_clr`  in  1  clears `overrun`.
- `rd_data`  out  8  head entry; 8'h00 when `empty`.
- `empty`  out  1  no entries held.
- `full`  out  1  `count` == `DEPTH`.
- `count`  out  $clog2(DEPTH)+1  entries held, 0..`DEPTH`.
- `overrun`  out  1  sticky: a byte was dropped.
- `irq`  out  1  `count` ≥ `IRQ_THRESHOLD`.

## Operation
- Storage: `DEPTH`×8 array. Write pointer `wptr` and read pointer `rptr`, each $clog2(DEPTH) bits, wrap modulo `DEPTH` by natural overflow. `count` is a separate register. Array contents are not reset.
- Push: `rx_valid`=1 and (not `full` or `pop` this cycle) → write `rx_data` at `wptr`, `wptr`+1.
- Drop: `rx_valid`=1, `full`=1, `pop`=0 → byte discarded, pointers and count unchanged, `overrun` set.
- Pop: `pop`=1 and `empty`=0 → `rptr`+1. `pop` while `empty` is a no-op, even with a simultaneous push.
- Count: +1 push only, −1 pop only, unchanged for both or neither. Never exceeds `DEPTH`, never wraps below 0.
- Flush: `rptr`, `wptr`, `count` ← 0. Takes priority over push and pop in the same cycle. A byte strobed in that cycle is discarded without setting `overrun`. `overrun` is unaffected by flush.
- Overrun: set by a drop; cleared by `overrun_clr`. A drop and a clear in the same cycle → stays set.
- `empty`, `full`, `irq` are decoded from the `count` register. `rd_data` = array[`rptr`] gated to 0 when `empty`.
- No state machine beyond pointer/count registers; behaviour is fully determined by the priority order flush > (push, pop).

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `overrun`=0, `irq`=0, `rd_data`=8'h00, pointers 0. A reset mid-stream discards all held data.
- Push latency: `rx_valid` in cycle N → `empty`=0, `count` updated, `rd_data` valid in N+1 (push into an empty FIFO).
- Pop: `pop` in cycle N → next head on `rd_data` and `count` decremented in N+1. Back-to-back pops every cycle are legal.
- `rd_data` is stable while `empty`=0 and no pop occurs; a push to a non-empty FIFO does not change it.
- `overrun` rises in the cycle after the drop. `irq` follows `count` with no additional delay.
- Throughput: one push and one pop per cycle, concurrently.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W` = 8, used here and by the receiver and transmitter.
- A single optional sub-module `uart_rx_fifo_mem`: storage array with a synchronous write port and an asynchronous read port. Pointer, count, and flag logic stay in `uart_rx_fifo`.

## Test plan
- Reset, then push 8'hA5 → next cycle `empty`=0, `count`=1, `rd_data`=8'hA5, `irq`=1 (threshold 1). Pop → `empty`=1, `rd_data`=8'h00.
- Push 8'h00..8'h0F (`DEPTH`=16) → `full`=1, `count`=16. Push 8'hFF → `overrun`=1, `count`=16. Pop all 16 → values 8'h00..8'h0F in order.
- Full FIFO, push 8'h55 with simultaneous pop → `count` stays 16, `overrun`=0, 8'h55 is the last entry read out.
- Overflow then assert `overrun_clr` in the same cycle as a second drop → `overrun` stays 1. Next cycle, `overrun_clr` alone → `overrun`=0.
- 40 interleaved push/pop operations crossing the pointer wrap → output sequence equals input sequence, `count` matches the scoreboard every cycle.
- Hold 5 entries, `flush` with simultaneous push 8'h77 → `count`=0, `empty`=1, `overrun` unchanged. Next push 8'h12 → `rd_data`=8'h12.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions used by the receiver, transmitter and
//               receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_mem
// Description : Byte storage for the UART receive buffer. It has one
//               synchronous write port and one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  // Contents are left unreset so the array can map onto distributed RAM.
  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : uart_rx_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive buffer behind the UART
//               receiver. It tracks the fill level, raises a level interrupt
//               at a threshold and keeps a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_W-1:0]    rx_data,
  input  logic                      rx_valid,
  input  logic                      pop,
  input  logic                      flush,
  input  logic                      overrun_clr,
  output logic [UART_DATA_W-1:0]    rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overrun,
  output logic                      irq
);

  localparam int                 c_PTR_W    = $clog2(DEPTH);
  localparam int                 c_CNT_W    = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_IRQ_CNT  = c_CNT_W'(IRQ_THRESHOLD);

  logic [c_PTR_W-1:0]     r_wptr;
  logic [c_PTR_W-1:0]     r_rptr;
  logic [c_CNT_W-1:0]     r_count;
  logic                   r_overrun;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic [UART_DATA_W-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);

  // Flush overrides both sides. A pop on a full buffer makes room for an
  // incoming byte in the same cycle.
  assign w_pop  = pop && !w_empty && !flush;
  assign w_push = rx_valid && !flush && (!w_full || w_pop);
  assign w_drop = rx_valid && !flush && w_full && !pop;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop wins over a clear issued in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (c_PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (rx_data),
    .raddr (r_rptr),
    .rdata (w_head)
  );

  assign rd_data = w_empty ? '0 : w_head;
  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;
  assign irq     = (r_count >= c_IRQ_CNT);

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench for uart_rx_fifo with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int THR   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       pop = 1'b0;
  logic       flush = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  uart_rx_fifo #(
    .DEPTH         (DEPTH),
    .IRQ_THRESHOLD (THR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .pop         (pop),
    .flush       (flush),
    .overrun_clr (overrun_clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         m_count  = 0;
  bit         m_ovr    = 1'b0;
  bit         chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: state outputs against the model each cycle; on every accepted pop
  // the presented head must match the scoreboard front.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), m_count);
      chk("empty", int'(empty), int'(m_count == 0));
      chk("full", int'(full), int'(m_count == DEPTH));
      chk("irq", int'(irq), int'(m_count >= THR));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (m_count == 0) chk("rd_data_empty", int'(rd_data), 0);
      if (pop && !flush && m_count > 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          chk("pop_data", int'(rd_data), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drive one cycle of inputs; the scoreboard push happens at issue time, the
  // model count/overrun follow the clock edge.
  task automatic step(input bit v, input logic [7:0] d, input bit p,
                      input bit f, input bit c);
    bit acc_push, acc_pop, drop;
    rx_valid    = v;
    rx_data     = d;
    pop         = p;
    flush       = f;
    overrun_clr = c;
    acc_pop  = p && (m_count > 0) && !f;
    acc_push = v && !f && ((m_count < DEPTH) || acc_pop);
    drop     = v && !f && (m_count == DEPTH) && !p;
    if (acc_push) exp_q.push_back(d);
    @(posedge clk);
    if (f) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      m_count = m_count + int'(acc_push) - int'(acc_pop);
    end
    if (drop) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    #1;
    rx_valid = 1'b0; pop = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    rx_valid = 1'b0; pop = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    m_count = 0;
    m_ovr   = 1'b0;
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_irq", int'(irq), 0);

    // Single byte fall-through and pop.
    step(1, 8'hA5, 0, 0, 0);
    chk("a5_rd_data", int'(rd_data), 8'hA5);
    chk("a5_count", int'(count), 1);
    chk("a5_irq", int'(irq), 1);
    step(0, 8'h00, 1, 0, 0);
    chk("a5_pop_empty", int'(empty), 1);
    chk("a5_pop_rd_data", int'(rd_data), 0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    chk("fill_full", int'(full), 1);
    step(1, 8'hFF, 0, 0, 0);
    chk("drop_overrun", int'(overrun), 1);
    chk("drop_count", int'(count), 16);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    chk("drain_empty", int'(empty), 1);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_overrun", int'(overrun), 0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_overrun", int'(overrun), 0);
    chk("fullpp_head", int'(rd_data), 8'h21);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
    chk("fullpp_last", int'(rd_data), 8'h55);
    step(0, 8'h00, 1, 0, 0);

    // Drop beats a simultaneous clear.
    for (int i = 0; i < 16; i++) step(1, 8'h40 + 8'(i), 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    step(1, 8'hFE, 0, 0, 1);
    chk("drop_vs_clr", int'(overrun), 1);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_alone", int'(overrun), 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);

    // Pop on empty with a simultaneous push is ignored on the read side.
    step(1, 8'h33, 1, 0, 0);
    chk("empty_pp_count", int'(count), 1);
    chk("empty_pp_data", int'(rd_data), 8'h33);
    step(0, 8'h00, 1, 0, 0);

    // Interleaved traffic crossing the pointer wrap.
    for (int i = 0; i < 40; i++)
      step((i % 3) != 2, 8'h80 + 8'(i), (i % 2) == 1, 0, 0);
    while (m_count > 0) step(0, 8'h00, 1, 0, 0);

    // Flush with a simultaneous strobe.
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0, 0);
    step(1, 8'h77, 0, 1, 0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_overrun", int'(overrun), 0);
    step(1, 8'h12, 0, 0, 0);
    chk("post_flush_data", int'(rd_data), 8'h12);
    step(0, 8'h00, 1, 0, 0);

    // Flush leaves a set overrun alone.
    for (int i = 0; i < 17; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    chk("flush_keeps_overrun", int'(overrun), 1);
    step(0, 8'h00, 0, 0, 1);

    // Reset mid-stream discards held data.
    for (int i = 0; i < 3; i++) step(1, 8'hD0 + 8'(i), 0, 0, 0);
    do_reset();
    chk("midreset_empty", int'(empty), 1);
    chk("midreset_count", int'(count), 0);
    step(1, 8'hE1, 0, 0, 0);
    chk("midreset_data", int'(rd_data), 8'hE1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_fifo
`default_nettype wire
